// File: rtl/rotate_seq_ctrl.sv
// Sequencing controller for an external rotate register: captures a command,
// loads the register, issues one rotate-enable per step, then presents the result.
module rotate_seq_ctrl #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_data,
  input  logic [AW-1:0] cmd_amt,
  output logic          reg_sync_rst,
  output logic          reg_load,
  output logic          reg_en,
  output logic [DW-1:0] reg_data,
  input  logic [DW-1:0] reg_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          busy
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  logic [2:0]    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] data_reg, data_next;
  logic [AW-1:0] amt_reg, amt_next;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_reg <= S_INIT;
      cnt_reg   <= '0;
      data_reg  <= '0;
      amt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      amt_reg   <= amt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    amt_next   = amt_reg;
    case (state_reg)
      S_INIT: state_next = S_IDLE;
      S_IDLE: begin
        if (cmd_valid) begin
          data_next  = cmd_data;
          amt_next   = cmd_amt;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_next   = amt_reg;
        state_next = (amt_reg != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        // Counter holds the steps still to issue, including the current one.
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // Moore decode only: no command/result handshake input reaches the strobes.
  assign reg_sync_rst = (state_reg == S_INIT);
  assign cmd_ready    = (state_reg == S_IDLE);
  assign busy         = (state_reg != S_IDLE);
  assign reg_load     = (state_reg == S_LOAD);
  assign reg_en       = (state_reg == S_SHIFT);
  assign res_valid    = (state_reg == S_DONE);
  assign reg_data     = data_reg;
  assign res_data     = reg_q;

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl: companion rotate register, transaction-timeline model
// checked every falling edge, plus directed scenarios with literal expectations.
module tb_rotate_seq_ctrl;
  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          async_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] cmd_amt = '0;
  logic          reg_sync_rst, reg_load, reg_en;
  logic [DW-1:0] reg_data;
  logic [DW-1:0] reg_q = 4'hA;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          busy;

  int checks = 0;
  int failures = 0;

  rotate_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .async_rst(async_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_amt(cmd_amt),
    .reg_sync_rst(reg_sync_rst), .reg_load(reg_load), .reg_en(reg_en),
    .reg_data(reg_data), .reg_q(reg_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Companion rotate register: sync_rst over load over en.
  always @(posedge clk) begin
    if (reg_sync_rst)  reg_q <= '0;
    else if (reg_load) reg_q <= reg_data;
    else if (reg_en)   reg_q <= {reg_q[0], reg_q[DW-1:1]};
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] d, input int a);
    logic [2*DW-1:0] t;
    t = {d, d} >> a;
    return t[DW-1:0];
  endfunction

  // Model: time since acceptance drives every expected output.
  bit            m_init = 1'b1;
  bit            m_pend = 1'b0;
  int            m_t = 0;
  logic [DW-1:0] m_data = '0;
  int            m_amt = 0;

  initial begin
    logic [5:0] exp_v;
    forever begin
      @(negedge clk);
      if (async_rst) begin
        chk("rst_outputs", 32'({reg_sync_rst, busy, cmd_ready, reg_load, reg_en, res_valid}), 32'(6'b110000));
        chk("rst_reg_data", 32'(reg_data), 32'(0));
        m_init = 1'b1; m_pend = 1'b0; m_t = 0; m_data = '0; m_amt = 0;
      end else begin
        if (m_init)       exp_v = 6'b110000;
        else if (!m_pend) exp_v = 6'b001000;
        else if (m_t == 1) exp_v = 6'b010100;
        else if (m_t <= m_amt + 1) exp_v = 6'b010010;
        else              exp_v = 6'b010001;
        chk("outputs", 32'({reg_sync_rst, busy, cmd_ready, reg_load, reg_en, res_valid}), 32'(exp_v));
        chk("reg_data", 32'(reg_data), 32'(m_data));
        if (exp_v[0]) chk("res_data", 32'(res_data), 32'(rotr(m_data, m_amt)));
        if (m_init) m_init = 1'b0;
        else if (!m_pend) begin
          if (cmd_valid) begin
            m_pend = 1'b1; m_t = 1; m_data = cmd_data; m_amt = int'(cmd_amt);
          end
        end else if (m_t >= m_amt + 2 && res_ready) m_pend = 1'b0;
        else m_t++;
      end
      chk("no_overlap", 32'(reg_load & reg_en), 32'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Run one command; hold res_ready low for 'hold' DONE cycles before the handshake.
  task automatic issue(input logic [DW-1:0] d, input int a, input int hold, input logic [DW-1:0] exp);
    int lat, ens, w;
    cmd_data = d; cmd_amt = AW'(a); res_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 50) begin step(); w++; end
    chk("ready_wait", 32'(w < 50), 32'(1));
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat = 1; ens = 0;
    while (!res_valid && lat < 50) begin
      if (reg_en) ens++;
      step(); lat++;
    end
    chk("latency", 32'(lat), 32'(a + 2));
    chk("en_pulses", 32'(ens), 32'(a));
    chk("res_literal", 32'(res_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_state", 32'({res_valid, cmd_ready, reg_en, reg_load}), 32'(4'b1000));
      chk("hold_data", 32'(res_data), 32'(exp));
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("ready_after_hs", 32'(cmd_ready), 32'(1));
    $display("txn data=%b amt=%0d latency=%0d en=%0d res=%b", d, a, lat, ens, res_data);
  endtask

  initial begin
    logic [DW-1:0] tbl [16];
    repeat (3) step();
    async_rst = 1'b0;
    chk("init_sync_rst", 32'({reg_sync_rst, busy, cmd_ready}), 32'(3'b110));
    step();
    chk("idle_after_init", 32'({reg_sync_rst, busy, cmd_ready}), 32'(3'b001));
    chk("reg_q_cleared", 32'(reg_q), 32'(0));
    $display("txn reset release: sync_rst one cycle, idle");

    issue(4'b1001, 1, 0, 4'b1100);
    issue(4'b0110, 0, 0, 4'b0110);
    issue(4'b0001, 3, 5, 4'b0010);
    issue(4'b1011, 2, 1, 4'b1110);

    // Reset pulse during the second SHIFT cycle of an amt=3 command.
    cmd_data = 4'b0111; cmd_amt = 2'd3; cmd_valid = 1'b1;
    step(); cmd_valid = 1'b0;
    step(); step();
    chk("in_shift", 32'(reg_en), 32'(1));
    async_rst = 1'b1;
    #1;
    chk("rst_drops_en", 32'({reg_en, reg_sync_rst, res_valid}), 32'(3'b010));
    step();
    async_rst = 1'b0;
    step();
    chk("idle_after_midrst", 32'({cmd_ready, busy, res_valid}), 32'(3'b100));
    chk("reg_q_after_midrst", 32'(reg_q), 32'(0));
    $display("txn mid-shift reset: command dropped");

    // Continuous cmd_valid with changing data; model checks each cycle.
    for (int i = 0; i < 16; i++) tbl[i] = DW'((i * 7 + 3) % 16);
    cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cmd_data = tbl[i % 16];
      cmd_amt = AW'(i % 4);
      res_ready = (i % 3 != 0);
      step();
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    repeat (8) step();
    $display("txn streaming: 60 cycles with cmd_valid held");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rotate_seq_ctrl.md
ROTATE_SEQ_CTRL -- requirements
Module: rotate_seq_ctrl

Interface
REQ-001 Parameters SHALL be: DW, 4, datapath width (power of two, >=2); AW, 2, rotate-amount width (log2 of DW).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 async_rst  input  1  asynchronous active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_data  input  DW  value to load into the rotate register.
REQ-007 cmd_amt  input  AW  number of right-rotate steps, 0..DW-1.
REQ-008 reg_sync_rst  output  1  synchronous clear to the rotate register.
REQ-009 reg_load  output  1  load strobe to the rotate register.
REQ-010 reg_en  output  1  rotate-enable strobe to the rotate register.
REQ-011 reg_data  output  DW  load value to the rotate register.
REQ-012 reg_q  input  DW  rotate register output.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  result consumer ready.
REQ-015 res_data  output  DW  result; equals reg_q, meaningful only while res_valid=1.
REQ-016 busy  output  1  high whenever the controller is not in IDLE.

Function
REQ-017 FSM states SHALL be INIT, IDLE, LOAD, SHIFT, DONE; all strobes decoded from state (Moore), no combinational path from cmd_*/res_ready to reg_* strobes.
REQ-018 INIT: reg_sync_rst=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 IDLE: cmd_ready=1; on cmd_valid=1 at a rising edge, capture cmd_data and cmd_amt into internal registers and go to LOAD; otherwise stay.
REQ-020 LOAD: reg_load=1, reg_en=0, reg_data=captured data, one cycle; next SHIFT if captured amt!=0, else DONE.
REQ-021 SHIFT: reg_en=1, reg_load=0; a down-counter initialised to amt decrements each cycle; leave to DONE after exactly amt SHIFT cycles.
REQ-022 DONE: res_valid=1, res_data=reg_q; hold until res_valid&&res_ready at an edge, then IDLE.
REQ-023 reg_load and reg_en SHALL never be high in the same cycle; reg_sync_rst SHALL be high only in INIT.
REQ-024 cmd_ready=0 in every state except IDLE; cmd_valid outside IDLE is ignored and does not alter captured values.
REQ-025 Latency: accept edge at cycle 0 -> res_valid first high in cycle amt+2; next cmd_ready in the cycle after the result handshake.
REQ-026 res_valid, res_data stable while res_ready=0 (register not strobed in DONE).
REQ-027 reg_data SHALL hold the last captured value outside LOAD (0 after reset).
REQ-028 Result SHALL equal cmd_data rotated right by cmd_amt ({q[0],q[DW-1:1]} per step), given the companion register (load priority over en, sync_rst priority over both).

Reset
REQ-029 async_rst=1 SHALL immediately force state=INIT, counter=0, captured data/amt=0, regardless of clock.
REQ-030 Outputs during and immediately after reset: reg_sync_rst=1, busy=1, cmd_ready=0, reg_load=0, reg_en=0, reg_data=0, res_valid=0.
REQ-031 Reset mid-operation (LOAD/SHIFT/DONE) SHALL drop the pending command and result; no further reg_en pulses issue.

Verification
REQ-032 Release async_rst -> exactly one cycle reg_sync_rst=1, then cmd_ready=1, busy=0, reg_q=0.
REQ-033 cmd_data=4'b1001, cmd_amt=1 -> one reg_load cycle, one reg_en cycle, res_valid in cycle 3 with res_data=4'b1100.
REQ-034 cmd_data=4'b0110, cmd_amt=0 -> no reg_en, res_valid in cycle 2, res_data=4'b0110.
REQ-035 cmd_data=4'b0001, cmd_amt=3, res_ready low 5 cycles -> three reg_en pulses, res_data=4'b0010 stable, cmd_ready=0 throughout; handshake then cmd_ready=1 next cycle.
REQ-036 async_rst pulsed during second SHIFT cycle of amt=3 -> reg_en drops same cycle, INIT then IDLE, no res_valid.
REQ-037 cmd_valid held high continuously with changing cmd_data -> each command accepted only in IDLE, results match captured values, reg_load/reg_en never overlap.
